// File: rtl/secure_key_fetch_pkg.sv
// Shared types and default configuration for the secure key fetch controller.
package secure_key_fetch_pkg;

    localparam int unsigned SkfWidth       = 256;
    localparam int unsigned SkfLength      = 16;
    localparam logic [15:0] SkfAllowedMask = 16'h0404;
    localparam int unsigned SkfTimeout     = 8;
    localparam int unsigned SkfCntW        = $clog2(SkfTimeout);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } skf_state_e;

endpackage

// File: rtl/skf_timeout_ctr.sv
// Response timeout counter: cleared before a wait, counts while enabled, flags TIMEOUT-1.
module skf_timeout_ctr
    import secure_key_fetch_pkg::*;
#(
    parameter int unsigned TIMEOUT = SkfTimeout,
    parameter int unsigned CntW    = SkfCntW
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/secure_key_fetch.sv
// Policy-checked single-read key fetch controller in front of the secure key memory.
// Optional build macro SECURE_KEY_FETCH_ZEROIZE_EN clears key_data on the consumer handshake.
module secure_key_fetch
    import secure_key_fetch_pkg::*;
#(
    parameter int unsigned        WIDTH        = SkfWidth,
    parameter int unsigned        LENGTH       = SkfLength,
    parameter logic [LENGTH-1:0]  ALLOWED_MASK = SkfAllowedMask,
    parameter int unsigned        TIMEOUT      = SkfTimeout,
    localparam int unsigned       AW           = $clog2(LENGTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AW-1:0]    req_slot,
    output logic             key_valid,
    input  logic             key_ready,
    output logic [WIDTH-1:0] key_data,
    output logic             key_err,
    output logic             mem_rd_en,
    output logic [AW-1:0]    mem_addr,
    input  logic [WIDTH-1:0] mem_rdData,
    input  logic             mem_rdData_valid,
    output logic             busy
);

    skf_state_e       state_q, state_d;
    logic             key_valid_q, key_valid_d;
    logic             key_err_q, key_err_d;
    logic [WIDTH-1:0] key_data_q, key_data_d;
    logic             mem_rd_en_q, mem_rd_en_d;
    logic [AW-1:0]    mem_addr_q, mem_addr_d;
    logic             expired;

    skf_timeout_ctr #(
        .TIMEOUT (TIMEOUT),
        .CntW    ($clog2(TIMEOUT))
    ) u_timeout_ctr (
        .clk_i     (clk),
        .rst_i     (rst),
        .clr_i     (state_q == StIssue),
        .en_i      (state_q == StWait),
        .expired_o (expired)
    );

    always_comb begin
        state_d     = state_q;
        key_valid_d = key_valid_q;
        key_err_d   = key_err_q;
        key_data_d  = key_data_q;
        mem_rd_en_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (ALLOWED_MASK[req_slot]) begin
                        state_d     = StIssue;
                        mem_addr_d  = req_slot;
                        mem_rd_en_d = 1'b1;
                    end else begin
                        // Denied slots never touch the memory.
                        state_d     = StResp;
                        key_valid_d = 1'b1;
                        key_err_d   = 1'b1;
                        key_data_d  = '0;
                    end
                end
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                if (mem_rdData_valid) begin
                    state_d     = StResp;
                    key_valid_d = 1'b1;
                    key_err_d   = 1'b0;
                    key_data_d  = mem_rdData;
                end else if (expired) begin
                    state_d     = StResp;
                    key_valid_d = 1'b1;
                    key_err_d   = 1'b1;
                    key_data_d  = '0;
                end
            end
            StResp: begin
                if (key_ready) begin
                    state_d     = StIdle;
                    key_valid_d = 1'b0;
`ifdef SECURE_KEY_FETCH_ZEROIZE_EN
                    key_data_d  = '0;
`endif
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            key_valid_q <= 1'b0;
            key_err_q   <= 1'b0;
            key_data_q  <= '0;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            key_valid_q <= key_valid_d;
            key_err_q   <= key_err_d;
            key_data_q  <= key_data_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    assign req_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign key_valid = key_valid_q;
    assign key_err   = key_err_q;
    assign key_data  = key_data_q;
    assign mem_rd_en = mem_rd_en_q;
    assign mem_addr  = mem_addr_q;

endmodule
